// File: rtl/cond_logic.sv
`default_nettype none
// ============================================================================
// cond_logic: ARM condition check, NZCV flag register and write-enable gating
// Rev 1.0
// ============================================================================
module cond_logic (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       CondLatch,
  input  logic       PCS,
  input  logic       NextPC,
  input  logic       RegW,
  input  logic       MemW,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] Flags
);

  localparam logic [3:0] C_COND_EQ = 4'b0000;
  localparam logic [3:0] C_COND_NE = 4'b0001;
  localparam logic [3:0] C_COND_CS = 4'b0010;
  localparam logic [3:0] C_COND_CC = 4'b0011;
  localparam logic [3:0] C_COND_MI = 4'b0100;
  localparam logic [3:0] C_COND_PL = 4'b0101;
  localparam logic [3:0] C_COND_VS = 4'b0110;
  localparam logic [3:0] C_COND_VC = 4'b0111;
  localparam logic [3:0] C_COND_HI = 4'b1000;
  localparam logic [3:0] C_COND_LS = 4'b1001;
  localparam logic [3:0] C_COND_GE = 4'b1010;
  localparam logic [3:0] C_COND_LT = 4'b1011;
  localparam logic [3:0] C_COND_GT = 4'b1100;
  localparam logic [3:0] C_COND_LE = 4'b1101;
  localparam logic [3:0] C_COND_AL = 4'b1110;

  logic [3:0] flags_q, flags_d;
  logic       cond_ex_q, cond_ex_d;
  logic       w_cond_pass;
  logic       w_n, w_z, w_c, w_v;

  // Condition is judged against the registered flags only, never ALUFlags.
  assign {w_n, w_z, w_c, w_v} = flags_q;

  always_comb begin
    w_cond_pass = 1'b0;
    case (Cond)
      C_COND_EQ: w_cond_pass = w_z;
      C_COND_NE: w_cond_pass = ~w_z;
      C_COND_CS: w_cond_pass = w_c;
      C_COND_CC: w_cond_pass = ~w_c;
      C_COND_MI: w_cond_pass = w_n;
      C_COND_PL: w_cond_pass = ~w_n;
      C_COND_VS: w_cond_pass = w_v;
      C_COND_VC: w_cond_pass = ~w_v;
      C_COND_HI: w_cond_pass = w_c & ~w_z;
      C_COND_LS: w_cond_pass = ~w_c | w_z;
      C_COND_GE: w_cond_pass = (w_n == w_v);
      C_COND_LT: w_cond_pass = (w_n != w_v);
      C_COND_GT: w_cond_pass = ~w_z & (w_n == w_v);
      C_COND_LE: w_cond_pass = w_z | (w_n != w_v);
      C_COND_AL: w_cond_pass = 1'b1;
      default:   w_cond_pass = 1'b0;
    endcase
  end

  // Flag groups are qualified by the old CondEx, so a same-cycle latch cannot bypass.
  always_comb begin
    flags_d   = flags_q;
    cond_ex_d = cond_ex_q;
    if (FlagW[1] && cond_ex_q) flags_d[3:2] = ALUFlags[3:2];
    if (FlagW[0] && cond_ex_q) flags_d[1:0] = ALUFlags[1:0];
    if (CondLatch) cond_ex_d = w_cond_pass;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q   <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  assign PCWrite  = (PCS & cond_ex_q) | NextPC;
  assign RegWrite = RegW & cond_ex_q;
  assign MemWrite = MemW & cond_ex_q;
  assign CondEx   = cond_ex_q;
  assign Flags    = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_cond_logic.sv
`default_nettype none
// ============================================================================
// tb_cond_logic: directed vectors, scoreboard queue, negedge monitor
// Rev 1.1
// ============================================================================
module tb_cond_logic;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] Cond = 4'b0;
    logic [3:0] ALUFlags = 4'b0;
    logic [1:0] FlagW = 2'b0;
    logic       CondLatch = 1'b0;
    logic       PCS = 1'b0;
    logic       NextPC = 1'b0;
    logic       RegW = 1'b0;
    logic       MemW = 1'b0;
    logic       PCWrite, RegWrite, MemWrite, CondEx;
    logic [3:0] Flags;

    typedef struct {
        string      name;
        logic [7:0] exp;   // {Flags, CondEx, PCWrite, RegWrite, MemWrite}
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    cond_logic dut (
        .clk(clk), .reset_n(reset_n), .Cond(Cond), .ALUFlags(ALUFlags),
        .FlagW(FlagW), .CondLatch(CondLatch), .PCS(PCS), .NextPC(NextPC),
        .RegW(RegW), .MemW(MemW), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .CondEx(CondEx), .Flags(Flags)
    );

    always #5 clk = ~clk;

    // Monitor: every negedge, drain pending expectations against live outputs.
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                exp_t e;
                logic [7:0] act;
                e   = q.pop_front();
                act = {Flags, CondEx, PCWrite, RegWrite, MemWrite};
                n_vec++;
                if (act !== e.exp) begin
                    n_bad++;
                    $display("FAIL %s: got {F,CX,PCW,RW,MW}=%b_%b%b%b%b expected %b_%b%b%b%b",
                             e.name, act[7:4], act[3], act[2], act[1], act[0],
                             e.exp[7:4], e.exp[3], e.exp[2], e.exp[1], e.exp[0]);
                end
            end
        end
    end

    function automatic logic [7:0] pack_exp(input logic [3:0] ef, input logic ecx,
                                            input logic pcs, input logic npc,
                                            input logic rw, input logic mw);
        return {ef, ecx, (pcs & ecx) | npc, rw & ecx, mw & ecx};
    endfunction

    // Drive one cycle's inputs just after posedge; expected values are the outputs
    // seen during that cycle (state from the previous edge).
    task automatic step(input string nm, input logic [3:0] cond, input logic [3:0] alu,
                        input logic [1:0] fw, input logic cl, input logic pcs,
                        input logic npc, input logic rw, input logic mw,
                        input logic [3:0] ef, input logic ecx);
        exp_t e;
        @(posedge clk);
        #1;
        Cond = cond; ALUFlags = alu; FlagW = fw; CondLatch = cl;
        PCS = pcs; NextPC = npc; RegW = rw; MemW = mw;
        e.name = nm;
        e.exp  = pack_exp(ef, ecx, pcs, npc, rw, mw);
        q.push_back(e);
    endtask

    logic [3:0]  sw_f [6];
    logic [15:0] sw_m [6];
    logic [3:0]  cur_f;
    logic        cur_cx;

    initial begin
        exp_t e;
        sw_f[0] = 4'b0000; sw_m[0] = 16'h56AA;
        sw_f[1] = 4'b0100; sw_m[1] = 16'h66A9;
        sw_f[2] = 4'b1001; sw_m[2] = 16'h565A;
        sw_f[3] = 4'b0010; sw_m[3] = 16'h55A6;
        sw_f[4] = 4'b1000; sw_m[4] = 16'h6A9A;
        sw_f[5] = 4'b0110; sw_m[5] = 16'h66A5;

        // Held in reset, with requests active and edges passing
        step("rst_hold_pcs",  4'hE, 4'hF, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0);
        step("rst_hold_npc",  4'hE, 4'hF, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0);
        @(negedge clk);
        #1;
        n_vec++;
        if (Flags !== 4'b0000) begin
            n_bad++;
            $display("FAIL in_reset_flags: got %b expected 0000", Flags);
        end
        n_vec++;
        if (CondEx !== 1'b0) begin
            n_bad++;
            $display("FAIL in_reset_condex: got %b expected 0", CondEx);
        end
        n_vec++;
        if (RegWrite !== 1'b0) begin
            n_bad++;
            $display("FAIL in_reset_regwrite: got %b expected 0", RegWrite);
        end
        n_vec++;
        if (MemWrite !== 1'b0) begin
            n_bad++;
            $display("FAIL in_reset_memwrite: got %b expected 0", MemWrite);
        end
        n_vec++;
        if (PCWrite !== 1'b1) begin
            n_bad++;
            $display("FAIL in_reset_pcwrite: got %b expected 1 (NextPC=1)", PCWrite);
        end
        CondLatch = 1'b0; FlagW = 2'b00; reset_n = 1'b1;

        // AL latch then gated enables
        step("post_rst_latchAL", 4'hE, 4'h0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0);
        step("al_enables",       4'hE, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b1);
        step("write_Z",          4'hE, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
        step("latch_EQ",         4'h0, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1);
        step("latch_NE",         4'h1, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0100, 1'b1);
        step("ne_blocks_rw",     4'h1, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0100, 1'b0);
        step("cx0_no_flagw",     4'h1, 4'hF, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b0);
        step("flags_unchanged",  4'h1, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0);

        // Independent flag groups
        step("relatch_AL",       4'hE, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0);
        step("clear_flags",      4'hE, 4'h0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1);
        step("fw01",             4'hE, 4'hF, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
        step("fw10",             4'hE, 4'hF, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0011, 1'b1);
        step("fw00_ignores_alu", 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1);
        step("fw00_held",        4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1);

        // Same-cycle latch and flag write: no bypass in either direction
        step("same_cyc_EQ",      4'h0, 4'h0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1);
        step("eq_used_old_Z",    4'h0, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
        step("same_cyc_oldcx0",  4'hE, 4'hF, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        step("old_cx0_blocked",  4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);

        // Condition sweep over several flag patterns
        cur_f = 4'b0000; cur_cx = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step($sformatf("sw%0d_latchAL", i), 4'hE, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, cur_f, cur_cx);
            cur_cx = 1'b1;
            step($sformatf("sw%0d_setf", i), 4'hE, sw_f[i], 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cur_f, cur_cx);
            cur_f = sw_f[i];
            for (int c = 0; c < 16; c++) begin
                step($sformatf("sw%0d_f%b_c%0d", i, cur_f, c), 4'(c), 4'h0, 2'b00, 1'b1,
                     1'b1, 1'b0, 1'b1, 1'b1, cur_f, cur_cx);
                cur_cx = sw_m[i][c];
            end
            step($sformatf("sw%0d_last", i), 4'hE, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, cur_f, cur_cx);
        end

        // Asynchronous reset between edges with a pending flag write
        step("pre_async_AL",  4'hE, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, cur_f, cur_cx);
        step("pre_async_set", 4'hE, 4'hF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cur_f, 1'b1);
        step("async_before",  4'hE, 4'h6, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (Flags !== 4'b0000) begin
            n_bad++;
            $display("FAIL async_flags_now: got %b expected 0000", Flags);
        end
        n_vec++;
        if (CondEx !== 1'b0) begin
            n_bad++;
            $display("FAIL async_condex_now: got %b expected 0", CondEx);
        end
        n_vec++;
        if (RegWrite !== 1'b0) begin
            n_bad++;
            $display("FAIL async_regwrite_now: got %b expected 0", RegWrite);
        end
        n_vec++;
        if (MemWrite !== 1'b0) begin
            n_bad++;
            $display("FAIL async_memwrite_now: got %b expected 0", MemWrite);
        end
        n_vec++;
        if (PCWrite !== 1'b0) begin
            n_bad++;
            $display("FAIL async_pcwrite_now: got %b expected 0", PCWrite);
        end
        e.name = "async_clear";
        e.exp  = pack_exp(4'b0000, 1'b0, PCS, NextPC, RegW, MemW);
        q.push_back(e);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        step("async_held",    4'hE, 4'h6, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0);

        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if (Flags !== 4'b0000) begin
            n_bad++;
            $display("FAIL post_async_flags_held: got %b expected 0000", Flags);
        end
        n_vec++;
        if (CondEx !== 1'b0) begin
            n_bad++;
            $display("FAIL post_async_condex_held: got %b expected 0", CondEx);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish by 100000 expected finish");
        n_bad++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/cond_logic.md
COND_LOGIC -- requirements
Module: cond_logic

Interface
REQ-001 The module SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 Cond  input  4  ARM condition field of the current instruction.
REQ-005 ALUFlags  input  4  {N,Z,C,V} from the ALU for the current operation.
REQ-006 FlagW  input  2  flag-write request: bit1 = N,Z group; bit0 = C,V group.
REQ-007 CondLatch  input  1  decode-state strobe; samples the condition result.
REQ-008 PCS  input  1  instruction writes PC (branch or PC destination).
REQ-009 NextPC  input  1  unconditional PC update (fetch state).
REQ-010 RegW  input  1  register-write request.
REQ-011 MemW  input  1  memory-write request.
REQ-012 PCWrite  output  1  gated PC write enable.
REQ-013 RegWrite  output  1  gated register write enable.
REQ-014 MemWrite  output  1  gated memory write enable.
REQ-015 CondEx  output  1  registered condition-passed bit.
REQ-016 Flags  output  4  architectural {N,Z,C,V} register contents.

Function
REQ-017 CondExD (internal, combinational) SHALL be computed from Cond and the registered Flags: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 0.
REQ-018 CondEx SHALL load CondExD on a rising edge when CondLatch=1 and SHALL hold otherwise.
REQ-019 Flags[3:2] SHALL load ALUFlags[3:2] on a rising edge when FlagW[1]=1 and CondEx=1; otherwise hold.
REQ-020 Flags[1:0] SHALL load ALUFlags[1:0] on a rising edge when FlagW[0]=1 and CondEx=1; otherwise hold.
REQ-021 Flag groups SHALL update independently; FlagW=01 leaves N,Z unchanged.
REQ-022 PCWrite SHALL equal (PCS & CondEx) | NextPC, combinationally, using the registered CondEx.
REQ-023 RegWrite SHALL equal RegW & CondEx; MemWrite SHALL equal MemW & CondEx.
REQ-024 Flags and CondEx SHALL be visible one cycle after the write edge (latency 1); gated enables have zero latency relative to their requests.
REQ-025 When CondLatch and FlagW are active in the same cycle, the flag update SHALL be qualified by the old CondEx, and the new CondEx SHALL be evaluated from the old Flags (no bypass).
REQ-026 NextPC=1 SHALL force PCWrite=1 regardless of CondEx or PCS.
REQ-027 ALUFlags SHALL be ignored when FlagW=00.

Reset
REQ-028 reset_n=0 SHALL asynchronously clear Flags to 4'b0000 and CondEx to 0 without waiting for clk.
REQ-029 During and after reset, until the first CondLatch, RegWrite, MemWrite SHALL be 0 and PCWrite SHALL equal NextPC.
REQ-030 Reset asserted mid-instruction SHALL discard any pending flag write on that edge; the reset value wins.

Verification
REQ-031 Reset, Cond=1110, CondLatch=1 one cycle -> CondEx=1; RegW=1,MemW=1 -> RegWrite=1,MemWrite=1.
REQ-032 CondEx=1, ALUFlags=0100, FlagW=11 -> Flags=0100; then Cond=0000 latched -> CondEx=1; Cond=0001 latched -> CondEx=0, RegWrite=0 with RegW=1.
REQ-033 Flags=0000, CondEx=1, ALUFlags=1111, FlagW=01 -> Flags=0011; FlagW=10 next -> Flags=1111.
REQ-034 Flags=1001 (N=1,V=1): Cond=1010 GE -> CondEx=1; Cond=1011 LT -> 0; Cond=1100 GT -> 1; Cond=1111 -> 0.
REQ-035 CondEx=0, FlagW=11, ALUFlags=1111 -> Flags unchanged; PCS=1,NextPC=0 -> PCWrite=0; NextPC=1 -> PCWrite=1.
REQ-036 Flags=1111, CondEx=1, FlagW=11 and reset_n pulsed low between edges -> Flags=0000, CondEx=0 immediately, held after the next edge.
